// File: rtl/pid_pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : pid_pwm_pkg                                                      |
// | Shared types and the saturate-to-duty helpers for the PID PWM output stage |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pid_pwm_pkg;

  typedef enum logic [1:0] {
    DT_OFF  = 2'd0,
    DT_WAIT = 2'd1,
    DT_ON   = 2'd2
  } dt_state_t;

  // Negative words clamp to 0; words above the period clamp to the period.
  function automatic logic [31:0] sat_duty(input logic signed [63:0] u,
                                           input logic [31:0] period);
    logic [31:0] d;
    d = u[31:0];
    if (u < 64'sd0)
      d = '0;
    else if (u > $signed({32'd0, period}))
      d = period;
    return d;
  endfunction

  // {hi, lo}; landing exactly on the period is not a saturation.
  function automatic logic [1:0] sat_flags(input logic signed [63:0] u,
                                           input logic [31:0] period);
    logic [1:0] f;
    f = 2'b00;
    if (u < 64'sd0)
      f = 2'b01;
    else if (u > $signed({32'd0, period}))
      f = 2'b10;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pid_pwm_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : pid_pwm_stage_if                                               |
// | Controller-side inputs and gate-drive/status outputs of the PWM stage      |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface pid_pwm_stage_if #(
  parameter int W     = 15,
  parameter int CNT_W = 10
);
  logic                 en;
  logic signed [W:0]    u_in;
  logic                 u_valid;
  logic                 pwm_h;
  logic                 pwm_l;
  logic                 period_start;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [CNT_W-1:0]     duty_q;

  modport master (
    output en, u_in, u_valid,
    input  pwm_h, pwm_l, period_start, sat_hi, sat_lo, duty_q
  );

  modport slave (
    input  en, u_in, u_valid,
    output pwm_h, pwm_l, period_start, sat_hi, sat_lo, duty_q
  );
endinterface
`default_nettype wire

// File: rtl/pwm_deadtime.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pwm_deadtime                                                     |
// | One gate leg: asserts after DEAD cycles of steady request, drops at once   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwm_deadtime
  import pid_pwm_pkg::*;
#(
  parameter int DEAD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic gate
);
  localparam logic [7:0] c_dead_m1 = 8'(DEAD - 1);

  dt_state_t  r_state, w_state_nxt;
  logic [7:0] r_dcnt, w_dcnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DT_OFF;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      DT_OFF: begin
        if (req) begin
          w_state_nxt = DT_WAIT;
          w_dcnt_nxt  = c_dead_m1;
        end
      end
      DT_WAIT: begin
        if (!req)
          w_state_nxt = DT_OFF;
        else if (r_dcnt == '0)
          w_state_nxt = DT_ON;
        else
          w_dcnt_nxt = r_dcnt - 1'b1;
      end
      DT_ON: begin
        if (!req)
          w_state_nxt = DT_OFF;
      end
      default: w_state_nxt = DT_OFF;
    endcase
  end

  assign gate = (r_state == DT_ON);

endmodule
`default_nettype wire

// File: rtl/pid_pwm_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pid_pwm_stage                                                    |
// | Saturating, double-buffered complementary edge-aligned PWM output stage.   |
// | Optional dead-time insertion when PWM_DEADTIME_EN is defined.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pid_pwm_stage
  import pid_pwm_pkg::*;
#(
  parameter int W      = 15,
  parameter int PERIOD = 1000,
  parameter int CNT_W  = 10,
  parameter int DEAD   = 8
) (
  input logic              clk,
  input logic              reset,
  pid_pwm_stage_if.slave   bus
);
  localparam logic [CNT_W-1:0] c_last   = CNT_W'(PERIOD - 1);
  localparam logic [31:0]      c_period = 32'(PERIOD);

  if (PERIOD < 2 || (64'd1 << CNT_W) <= 64'(PERIOD) || DEAD < 1 || DEAD > 255) begin : g_bad_params
    $error("pid_pwm_stage: illegal PERIOD/CNT_W/DEAD combination");
  end

  logic [CNT_W-1:0]   r_cnt, r_shadow, r_active, w_sat_duty;
  logic               r_sat_hi, r_sat_lo;
  logic [1:0]         w_sat_flags;
  logic signed [63:0] w_u_ext;
  logic               w_period_end, w_period_start, w_load, w_raw;

  assign w_u_ext        = 64'(bus.u_in);
  assign w_sat_duty     = CNT_W'(sat_duty(w_u_ext, c_period));
  assign w_sat_flags    = sat_flags(w_u_ext, c_period);
  assign w_period_end   = bus.en && (r_cnt == c_last);
  assign w_period_start = bus.en && (r_cnt == '0);
  // Reloading at every period start is a no-op in steady state and covers re-enable.
  assign w_load         = w_period_end || w_period_start;
  assign w_raw          = bus.en && (r_cnt < r_active);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
    end else begin
      r_cnt <= (!bus.en || w_period_end) ? '0 : r_cnt + 1'b1;
      if (bus.u_valid) begin
        r_shadow <= w_sat_duty;
        r_sat_hi <= w_sat_flags[1];
        r_sat_lo <= w_sat_flags[0];
      end
      if (w_period_end && bus.u_valid)
        r_active <= w_sat_duty;
      else if (w_load)
        r_active <= r_shadow;
    end
  end

`ifdef PWM_DEADTIME_EN
  logic w_gate_h, w_gate_l;

  pwm_deadtime #(.DEAD(DEAD)) u_dt_h (
    .clk   (clk),
    .reset (reset),
    .req   (w_raw),
    .gate  (w_gate_h)
  );

  pwm_deadtime #(.DEAD(DEAD)) u_dt_l (
    .clk   (clk),
    .reset (reset),
    .req   (bus.en && !w_raw),
    .gate  (w_gate_l)
  );

  assign bus.pwm_h = w_gate_h;
  assign bus.pwm_l = w_gate_l;
`else
  logic r_pwm_h, r_pwm_l;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_h <= 1'b0;
      r_pwm_l <= 1'b0;
    end else begin
      r_pwm_h <= w_raw;
      r_pwm_l <= bus.en && !w_raw;
    end
  end

  assign bus.pwm_h = r_pwm_h;
  assign bus.pwm_l = r_pwm_l;
`endif

  // Gated by reset so the strobe stays quiet while the stage is held in reset.
  assign bus.period_start = w_period_start && !reset;
  assign bus.sat_hi       = r_sat_hi;
  assign bus.sat_lo       = r_sat_lo;
  assign bus.duty_q       = r_active;

endmodule
`default_nettype wire

// File: tb/tb_pid_pwm_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pid_pwm_stage                                                 |
// | Directed + random bench for pid_pwm_stage against a run-length model       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pid_pwm_stage;
  localparam int W      = 15;
  localparam int PERIOD = 10;
  localparam int CNT_W  = 4;
  localparam int DEAD   = 2;
`ifdef PWM_DEADTIME_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif
  // A gate is expected high once its request has held this many consecutive cycles.
  localparam int HOLD = DT ? DEAD + 1 : 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pid_pwm_stage_if #(.W(W), .CNT_W(CNT_W)) bus ();

  pid_pwm_stage #(.W(W), .PERIOD(PERIOD), .CNT_W(CNT_W), .DEAD(DEAD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in period, duty registers, request run lengths.
  int m_pos, m_shadow, m_active, m_run_h, m_run_l, m_u;
  bit m_hi, m_lo, m_h, m_l, m_en_prev, m_raw;

  always @(posedge clk) begin
    if (reset) begin
      m_pos = 0; m_shadow = 0; m_active = 0; m_run_h = 0; m_run_l = 0;
      m_hi = 0; m_lo = 0; m_h = 0; m_l = 0; m_en_prev = 0;
    end else begin
      m_raw   = bus.en && (m_pos < m_active);
      m_run_h = m_raw ? m_run_h + 1 : 0;
      m_run_l = (bus.en && !m_raw) ? m_run_l + 1 : 0;
      m_h     = (m_run_h >= HOLD);
      m_l     = (m_run_l >= HOLD);
      m_u     = int'(bus.u_in);
      if (m_u < 0)           m_u = 0;
      else if (m_u > PERIOD) m_u = PERIOD;
      if (bus.en && m_pos == PERIOD - 1)
        m_active = bus.u_valid ? m_u : m_shadow;
      else if (bus.en && !m_en_prev)
        m_active = m_shadow;
      if (bus.u_valid) begin
        m_shadow = m_u;
        m_lo = (int'(bus.u_in) < 0);
        m_hi = (int'(bus.u_in) > PERIOD);
      end
      m_pos     = bus.en ? (m_pos + 1) % PERIOD : 0;
      m_en_prev = bus.en;
    end
  end

  task automatic tick(input bit v, input int u);
    bus.u_valid = v;
    bus.u_in    = 16'(u);
    @(negedge clk);
    check("pwm_h", bus.pwm_h, m_h);
    check("pwm_l", bus.pwm_l, m_l);
    check("duty_q", bus.duty_q, m_active);
    check("sat_hi", bus.sat_hi, m_hi);
    check("sat_lo", bus.sat_lo, m_lo);
    check("period_start", bus.period_start, !reset && bus.en && m_pos == 0);
    bus.u_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 2 * PERIOD && m_pos != p; i++) tick(0, 0);
  endtask

  // Counts over one full period of steady duty, checked against spec-derived figures.
  task automatic measure(input string tag, input int exp_h, input int exp_l);
    int nh = 0, nl = 0, ns = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick(0, 0);
      nh += int'(bus.pwm_h);
      nl += int'(bus.pwm_l);
      ns += int'(bus.period_start);
    end
    check({tag, "_h_count"}, nh, exp_h);
    check({tag, "_l_count"}, nl, exp_l);
    check({tag, "_ps_count"}, ns, 1);
  endtask

  task automatic apply(input int u);
    tick(1, u);
    idle(2 * PERIOD + 2);
  endtask

  int r, t;

  initial begin
    reset = 1'b1; bus.en = 1'b0; bus.u_valid = 1'b0; bus.u_in = '0;
    idle(3);
    check("reset_duty", bus.duty_q, 0);
    reset = 1'b0;
    bus.en = 1'b1;
    idle(3);

    apply(4);
    measure("duty4", DT ? 2 : 4, DT ? 4 : 6);
    apply(-5);
    check("neg_sat_lo", bus.sat_lo, 1);
    measure("duty0", 0, 10);
    apply(1000);
    check("big_sat_hi", bus.sat_hi, 1);
    check("big_duty", bus.duty_q, PERIOD);
    measure("duty10", 10, 0);
    apply(PERIOD);
    check("exact_no_sat_hi", bus.sat_hi, 0);
    apply(1);
    measure("duty1", DT ? 0 : 1, DT ? 7 : 9);

    run_to(3);
    tick(1, 3);
    run_to(PERIOD - 1);
    tick(1, 7);
    check("dbl_strobe_duty", bus.duty_q, 7);
    idle(1);
    measure("duty7", DT ? 5 : 7, DT ? 1 : 3);

    run_to(5);
    bus.en = 1'b0;
    tick(0, 0);
    check("en_off_h", bus.pwm_h, 0);
    tick(1, 6);
    idle(2);
    bus.en = 1'b1;
    #1;
    check("ps_on_reenable", bus.period_start, 1);
    tick(0, 0);
    check("reenable_duty", bus.duty_q, 6);

    run_to(3);
    reset = 1'b1;
    tick(0, 0);
    check("rst_mid_duty", bus.duty_q, 0);
    reset = 1'b0;
    idle(2 * PERIOD);
    measure("post_reset", 0, 10);

    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) bus.en = ~bus.en;
      r = $urandom_range(0, 4);
      case (r)
        0: begin t = $urandom_range(1, 32768); t = -t; end
        1: t = $urandom_range(PERIOD + 1, 32767);
        2: t = PERIOD;
        default: t = $urandom_range(0, PERIOD);
      endcase
      tick($urandom_range(0, 7) == 0, t);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
